// File: rtl/pong_pkg.sv
// Shared Pong definitions: paddle direction state encoding and screen geometry.
package pong_pkg;

    typedef enum logic [1:0] {
        SIDLE = 2'b00,
        SUP   = 2'b01,
        SDOWN = 2'b10
    } dir_state_t;

    localparam logic [9:0] SCREEN_WIDTH  = 10'd640;
    localparam logic [9:0] SCREEN_HEIGHT = 10'd480;

endpackage

// File: rtl/paddle_dir_fsm.sv
// Per-paddle direction FSM: steps only on tick, emits one-cycle move pulses.
// A reversal always passes through SIDLE for one full step period.
module paddle_dir_fsm
    import pong_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic req_up,
    input  logic req_down,
    input  logic force_idle,
    output logic move_up,
    output logic move_down
);

    dir_state_t state_q, state_d;
    logic       move_up_q, move_up_d;
    logic       move_down_q, move_down_d;

    always_comb begin
        state_d     = state_q;
        move_up_d   = 1'b0;
        move_down_d = 1'b0;
        if (force_idle) begin
            state_d = SIDLE;
        end else if (tick) begin
            case (state_q)
                SIDLE:   state_d = req_up ? SUP : (req_down ? SDOWN : SIDLE);
                SUP:     state_d = req_up ? SUP : SIDLE;
                SDOWN:   state_d = req_down ? SDOWN : SIDLE;
                default: state_d = SIDLE;
            endcase
            move_up_d   = (state_d == SUP);
            move_down_d = (state_d == SDOWN);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SIDLE;
            move_up_q   <= 1'b0;
            move_down_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            move_up_q   <= move_up_d;
            move_down_q <= move_down_d;
        end
    end

    assign move_up   = move_up_q;
    assign move_down = move_down_q;

endmodule

// File: rtl/paddle_move_ctrl.sv
// Paddle move scheduler: button synchronizers, step-rate counter, CPU ball
// tracker for the right paddle, and two direction FSMs.
module paddle_move_ctrl
    import pong_pkg::*;
#(
    parameter int         STEP_DIV  = 250000,
    parameter logic [9:0] DEAD_BAND = 10'd4
) (
    input  logic       CLK_100MHz,
    input  logic       Reset,
    input  logic       btnUpL,
    input  logic       btnDownL,
    input  logic       btnUpR,
    input  logic       btnDownR,
    input  logic       cpuR,
    input  logic [9:0] ballVmin,
    input  logic [9:0] ballVmax,
    input  logic [9:0] padRVmin,
    input  logic [9:0] padRVmax,
    output logic       stepTick,
    output logic       moveUpL,
    output logic       moveDownL,
    output logic       moveUpR,
    output logic       moveDownR
);

    localparam int            CW       = $clog2(STEP_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(STEP_DIV - 1);

    // bit order: {up_l, down_l, up_r, down_r}
    logic [3:0]    sync1_q, sync1_d, sync2_q, sync2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          step_tick_q, step_tick_d;
    logic          trk_up_q, trk_up_d, trk_dn_q, trk_dn_d;
    logic          cpu_prev_q, cpu_prev_d;

    logic [10:0]   ball_sum, pad_sum, ball_c, pad_c;
    logic          req_up_l, req_dn_l, req_up_r, req_dn_r;

    always_comb begin
        sync1_d     = {btnUpL, btnDownL, btnUpR, btnDownR};
        sync2_d     = sync1_q;
        cnt_d       = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        step_tick_d = (cnt_q == CNT_LAST);
        cpu_prev_d  = cpuR;

        ball_sum = {1'b0, ballVmin} + {1'b0, ballVmax};
        pad_sum  = {1'b0, padRVmin} + {1'b0, padRVmax};
        ball_c   = ball_sum >> 1;
        pad_c    = pad_sum >> 1;
        trk_up_d = (ball_c + {1'b0, DEAD_BAND}) < pad_c;
        trk_dn_d = ball_c > (pad_c + {1'b0, DEAD_BAND});

        req_up_l = sync2_q[3] & ~sync2_q[2];
        req_dn_l = sync2_q[2] & ~sync2_q[3];
        if (cpuR) begin
            req_up_r = trk_up_q;
            req_dn_r = trk_dn_q;
        end else begin
            req_up_r = sync2_q[1] & ~sync2_q[0];
            req_dn_r = sync2_q[0] & ~sync2_q[1];
        end
    end

    always_ff @(posedge CLK_100MHz) begin
        if (Reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            cnt_q       <= '0;
            step_tick_q <= 1'b0;
            trk_up_q    <= 1'b0;
            trk_dn_q    <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            cnt_q       <= cnt_d;
            step_tick_q <= step_tick_d;
            trk_up_q    <= trk_up_d;
            trk_dn_q    <= trk_dn_d;
        end
    end

    // Tracks cpuR through reset too, so a mode held across reset is not a change.
    always_ff @(posedge CLK_100MHz) begin
        cpu_prev_q <= cpu_prev_d;
    end

    paddle_dir_fsm u_fsm_l (
        .clk        (CLK_100MHz),
        .rst        (Reset),
        .tick       (step_tick_q),
        .req_up     (req_up_l),
        .req_down   (req_dn_l),
        .force_idle (1'b0),
        .move_up    (moveUpL),
        .move_down  (moveDownL)
    );

    paddle_dir_fsm u_fsm_r (
        .clk        (CLK_100MHz),
        .rst        (Reset),
        .tick       (step_tick_q),
        .req_up     (req_up_r),
        .req_down   (req_dn_r),
        .force_idle (cpuR ^ cpu_prev_q),
        .move_up    (moveUpR),
        .move_down  (moveDownR)
    );

    assign stepTick = step_tick_q;

endmodule

// File: tb/tb_paddle_move_ctrl.sv
// Bench for paddle_move_ctrl: directed and randomized stimulus against a
// pulse-level reference model kept per clock edge.
module tb_paddle_move_ctrl;

    localparam int STEP_DIV = 4;
    localparam int DB       = 4;
    localparam int N        = 4096;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bul = 1'b0, bdl = 1'b0, bur = 1'b0, bdr = 1'b0, cpu = 1'b0;
    logic [9:0] bvmin = 10'd0, bvmax = 10'd0, pvmin = 10'd0, pvmax = 10'd0;
    logic       stepTick, moveUpL, moveDownL, moveUpR, moveDownR;

    always #5 clk = ~clk;

    paddle_move_ctrl #(.STEP_DIV(STEP_DIV), .DEAD_BAND(10'd4)) dut (
        .CLK_100MHz (clk),
        .Reset      (rst),
        .btnUpL     (bul),
        .btnDownL   (bdl),
        .btnUpR     (bur),
        .btnDownR   (bdr),
        .cpuR       (cpu),
        .ballVmin   (bvmin),
        .ballVmax   (bvmax),
        .padRVmin   (pvmin),
        .padRVmax   (pvmax),
        .stepTick   (stepTick),
        .moveUpL    (moveUpL),
        .moveDownL  (moveDownL),
        .moveUpR    (moveUpR),
        .moveDownR  (moveDownR)
    );

    int checks = 0;
    int errors = 0;

    // Input history, indexed by clock edge number.
    logic       h_rst [N];
    logic [3:0] h_btn [N];
    logic       h_cpu [N];
    int         h_bc  [N];
    int         h_pc  [N];

    // Model: last direction issued per paddle (0 none, 1 up, 2 down).
    int   n = 0;
    int   last_rst = 0;
    int   ldir_l = 0, ldir_r = 0;
    int   e_l = 0, e_r = 0;
    logic e_tick = 1'b0;

    function automatic int req_btn(logic u, logic d);
        if (u && !d) return 1;
        if (d && !u) return 2;
        return 0;
    endfunction

    function automatic int trk(int bc, int pc);
        if (bc + DB < pc) return 1;
        if (bc > pc + DB) return 2;
        return 0;
    endfunction

    function automatic int issue(int last, int req);
        if (last == 0 || req == last) return req;
        return 0;
    endfunction

    task automatic chk(string tag, logic obs, logic exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s @edge %0d: observed %b expected %b", tag, n, obs, exp_v);
        end
    endtask

    task automatic cyc();
        logic       tick_pre;
        logic [3:0] sb;
        int         rl, rr;
        if (n >= N - 1) begin
            $display("FAIL edge_budget: observed %0d edges, limit %0d", n, N - 1);
            $fatal(1, "edge budget exhausted");
        end
        h_rst[n] = rst;
        h_btn[n] = {bul, bdl, bur, bdr};
        h_cpu[n] = cpu;
        h_bc[n]  = (int'(bvmin) + int'(bvmax)) / 2;
        h_pc[n]  = (int'(pvmin) + int'(pvmax)) / 2;
        @(posedge clk);
        #1;
        tick_pre = e_tick;
        e_l = 0;
        e_r = 0;
        if (rst) begin
            last_rst = n;
            e_tick   = 1'b0;
            ldir_l   = 0;
            ldir_r   = 0;
        end else begin
            e_tick = ((n - last_rst) % STEP_DIV == 0);
            sb = (n >= 2 && !h_rst[n-1] && !h_rst[n-2]) ? h_btn[n-2] : 4'b0000;
            rl = req_btn(sb[3], sb[2]);
            if (h_cpu[n])
                rr = (n >= 1 && !h_rst[n-1]) ? trk(h_bc[n-1], h_pc[n-1]) : 0;
            else
                rr = req_btn(sb[1], sb[0]);
            if (tick_pre) begin
                ldir_l = issue(ldir_l, rl);
                e_l    = ldir_l;
            end
            if (n >= 1 && h_cpu[n] != h_cpu[n-1]) begin
                ldir_r = 0;
            end else if (tick_pre) begin
                ldir_r = issue(ldir_r, rr);
                e_r    = ldir_r;
            end
        end
        chk("stepTick",  stepTick,  e_tick);
        chk("moveUpL",   moveUpL,   e_l == 1);
        chk("moveDownL", moveDownL, e_l == 2);
        chk("moveUpR",   moveUpR,   e_r == 1);
        chk("moveDownR", moveDownR, e_r == 2);
        chk("excl_L",    moveUpL & moveDownL, 1'b0);
        chk("excl_R",    moveUpR & moveDownR, 1'b0);
        n++;
    endtask

    task automatic wait_tick_visible(string tag);
        int k;
        k = 0;
        while (!e_tick && k < 3 * STEP_DIV) begin
            cyc();
            k++;
        end
        checks++;
        assert (e_tick) else begin
            errors++;
            $error("FAIL %s: observed no tick within %0d cycles, required a tick", tag, k);
        end
    endtask

    initial begin
        // Reset for 3 cycles, then first tick 4 cycles after release.
        rst = 1'b1;
        repeat (3) cyc();
        chk("reset_upL", moveUpL, 1'b0);
        chk("reset_tick", stepTick, 1'b0);
        rst = 1'b0;
        repeat (3) cyc();
        chk("tick_early", stepTick, 1'b0);
        cyc();
        chk("first_tick", stepTick, 1'b1);

        // Hold left up.
        bul = 1'b1;
        repeat (20) cyc();
        // Both left buttons.
        bdl = 1'b1;
        repeat (12) cyc();
        // Reversal: up, then down.
        bdl = 1'b0;
        repeat (12) cyc();
        bul = 1'b0;
        bdl = 1'b1;
        repeat (16) cyc();
        bdl = 1'b0;
        repeat (6) cyc();

        // Random button traffic.
        repeat (60) begin
            {bul, bdl, bur, bdr} = 4'($urandom_range(0, 15));
            repeat ($urandom_range(1, 10)) cyc();
        end

        // CPU tracking: ball far above paddle, right buttons toggled.
        cpu   = 1'b1;
        bvmin = 10'd100; bvmax = 10'd110;
        pvmin = 10'd270; pvmax = 10'd330;
        repeat (24) begin
            {bul, bdl, bur, bdr} = 4'($urandom_range(0, 15));
            cyc();
        end
        // Ball centered on paddle.
        bvmin = 10'd295; bvmax = 10'd305;
        repeat (24) begin
            {bul, bdl, bur, bdr} = 4'($urandom_range(0, 15));
            cyc();
        end

        // Random tracker geometry with occasional mode flips.
        repeat (50) begin
            bvmin = 10'($urandom_range(0, 1000));
            bvmax = 10'(int'(bvmin) + $urandom_range(0, 23));
            pvmin = 10'($urandom_range(0, 960));
            pvmax = 10'(int'(pvmin) + $urandom_range(0, 63));
            {bul, bdl, bur, bdr} = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) cpu = ~cpu;
            repeat ($urandom_range(1, 10)) cyc();
        end

        // Mode switch in a tick cycle, with an up request pending in both modes.
        cpu   = 1'b1;
        bvmin = 10'd100; bvmax = 10'd110;
        pvmin = 10'd270; pvmax = 10'd330;
        {bul, bdl, bur, bdr} = 4'b0010;
        repeat (12) cyc();
        repeat (3) begin
            wait_tick_visible("mode_tick_wait");
            cpu = ~cpu;
            cyc();
            chk("mode_sw_upR", moveUpR, 1'b0);
            chk("mode_sw_dnR", moveDownR, 1'b0);
            repeat (9) cyc();
        end

        // Reset asserted during a left pulse cycle.
        bul = 1'b1;
        bdl = 1'b0;
        begin
            int k;
            k = 0;
            while (e_l != 1 && k < 4 * STEP_DIV) begin
                cyc();
                k++;
            end
            checks++;
            assert (e_l == 1) else begin
                errors++;
                $error("FAIL pulse_wait: observed no left pulse within %0d cycles, required one", k);
            end
        end
        rst = 1'b1;
        cyc();
        chk("midrst_upL",  moveUpL,  1'b0);
        chk("midrst_tick", stepTick, 1'b0);
        rst = 1'b0;
        repeat (16) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
